// File: rtl/clock_pkg.sv
// Shared encodings for the clock time-set controller: mode codes, FSM states and blank masks.
// Pure definitions; no timing or flow control.
package clock_pkg;

    localparam logic [1:0] MODE_RUN  = 2'd0;
    localparam logic [1:0] MODE_HOUR = 2'd1;
    localparam logic [1:0] MODE_MIN  = 2'd2;
    localparam logic [1:0] MODE_SEC  = 2'd3;

    localparam logic [5:0] BLANK_HOUR = 6'b110000;
    localparam logic [5:0] BLANK_MIN  = 6'b001100;
    localparam logic [5:0] BLANK_SEC  = 6'b000011;

    typedef enum logic [1:0] {
        ST_RUN  = MODE_RUN,
        ST_HOUR = MODE_HOUR,
        ST_MIN  = MODE_MIN,
        ST_SEC  = MODE_SEC
    } state_t;

    function automatic state_t next_mode(input state_t s);
        case (s)
            ST_RUN:  return ST_HOUR;
            ST_HOUR: return ST_MIN;
            ST_MIN:  return ST_SEC;
            default: return ST_RUN;
        endcase
    endfunction

    function automatic logic [5:0] blank_mask(input state_t s);
        case (s)
            ST_HOUR: return BLANK_HOUR;
            ST_MIN:  return BLANK_MIN;
            ST_SEC:  return BLANK_SEC;
            default: return 6'b000000;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Key conditioner: 2-FF sync, level accepted after DEBOUNCE_CYC equal samples, registered press pulse.
// Press appears DEBOUNCE_CYC+2 clocks after the raw key falls; no backpressure.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            cnt   <= '0;
            level <= 1'b1;
            press <= 1'b0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            press <= 1'b0;
            // cnt counts consecutive samples that disagree with the accepted level
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                cnt   <= '0;
                level <= sync2;
                press <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set controller: debounced MODE/INC keys drive RUN/SET_* FSM, counter strobes, run gate, blink.
// Strobes one clock after the press pulse; no backpressure. AUTO_REPEAT_EN adds INC auto-repeat.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYC      = 50000,
    parameter int TIMEOUT_S         = 10,
    parameter int REPEAT_START_CYC  = 25000000,
    parameter int REPEAT_PERIOD_CYC = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic       run_en,
    output logic       inc_hour,
    output logic       inc_min,
    output logic       clr_sec,
    output logic [5:0] blank,
    output logic [1:0] mode
);

`ifdef AUTO_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    localparam int TW      = $clog2(TIMEOUT_S + 1);
    localparam int REP_MAX = (REPEAT_START_CYC > REPEAT_PERIOD_CYC) ? REPEAT_START_CYC
                                                                      : REPEAT_PERIOD_CYC;
    localparam int RW      = $clog2(REP_MAX + 1);

    logic mode_press;
    logic mode_level_unused;
    logic inc_press;
    logic inc_level;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_mode_key (
        .clk   (clk),
        .rst   (rst),
        .key   (key_mode),
        .level (mode_level_unused),
        .press (mode_press)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_inc_key (
        .clk   (clk),
        .rst   (rst),
        .key   (key_inc),
        .level (inc_level),
        .press (inc_press)
    );

    state_t        state;
    state_t        nxt_state;
    logic          phase;
    logic          nxt_phase;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] nxt_tcnt;
    logic          nxt_hour;
    logic          nxt_min;
    logic          nxt_clr;

    logic          rep_armed;
    logic          rep_period;
    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_target;
    logic          rep_field;
    logic          rep_fire;

    assign rep_field  = (state == ST_HOUR) || (state == ST_MIN);
    assign rep_target = rep_period ? RW'(REPEAT_PERIOD_CYC - 1) : RW'(REPEAT_START_CYC - 1);
    assign rep_fire   = REPEAT_ON && rep_armed && rep_field && !inc_level && (rep_cnt == rep_target);

    // Repeat timer runs from the accepted press while INC stays held in an hour/minute field
    always_ff @(posedge clk) begin
        if (!rst) begin
            rep_armed  <= 1'b0;
            rep_period <= 1'b0;
            rep_cnt    <= '0;
        end else if (!REPEAT_ON || mode_press || !rep_field) begin
            rep_armed  <= 1'b0;
        end else if (inc_press) begin
            rep_armed  <= 1'b1;
            rep_period <= 1'b0;
            rep_cnt    <= '0;
        end else if (rep_armed) begin
            if (inc_level) begin
                rep_armed <= 1'b0;
            end else if (rep_fire) begin
                rep_cnt    <= '0;
                rep_period <= 1'b1;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_phase = phase ^ tick_1hz;
        nxt_tcnt  = tcnt;
        nxt_hour  = 1'b0;
        nxt_min   = 1'b0;
        nxt_clr   = 1'b0;
        if (mode_press) begin
            nxt_state = next_mode(state);
        end else if (state != ST_RUN) begin
            if (inc_press || rep_fire) begin
                nxt_tcnt = '0;
                case (state)
                    ST_HOUR: nxt_hour = 1'b1;
                    ST_MIN:  nxt_min  = 1'b1;
                    default: nxt_clr  = 1'b1;
                endcase
            end else if (tick_1hz) begin
                nxt_tcnt = tcnt + 1'b1;
                if (nxt_tcnt == TW'(TIMEOUT_S)) begin
                    nxt_state = ST_RUN;
                end
            end
        end
        // A fresh field starts visible and with a full timeout window
        if (nxt_state != state) begin
            nxt_phase = 1'b0;
            nxt_tcnt  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_RUN;
            phase    <= 1'b0;
            tcnt     <= '0;
            run_en   <= 1'b1;
            inc_hour <= 1'b0;
            inc_min  <= 1'b0;
            clr_sec  <= 1'b0;
            blank    <= '0;
            mode     <= MODE_RUN;
        end else begin
            state    <= nxt_state;
            phase    <= nxt_phase;
            tcnt     <= nxt_tcnt;
            run_en   <= (nxt_state == ST_RUN);
            inc_hour <= nxt_hour;
            inc_min  <= nxt_min;
            clr_sec  <= nxt_clr;
            blank    <= nxt_phase ? blank_mask(nxt_state) : 6'b000000;
            mode     <= nxt_state;
        end
    end

endmodule
